// File: rtl/bp_trace_driver.sv
// Replays a preloaded branch trace into the tournament predictor, honouring its
// PC-hold and slowclock timing, and tallies branches and mispredictions.
module bp_trace_driver #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned WINDOW     = 10,
    parameter int unsigned SAMPLE_CYC = 3,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [PC_W-1:0]  load_pc,
    input  logic             load_taken,
    input  logic [AW:0]      trace_len,
    input  logic             start,
    input  logic             PredictedBranch,
    output logic [PC_W-1:0]  PC,
    output logic             BranchTaken,
    output logic             slowclock,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [7:0]       WLAST   = 8'(WINDOW - 1);
    localparam logic [7:0]       WSAMP   = 8'(SAMPLE_CYC);
    localparam logic [AW:0]      LEN_ONE = 1;
    localparam logic [AW-1:0]    IDX_ONE = 1;
    localparam logic [AW-1:0]    IDX0    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [PC_W:0]   mem [DEPTH];
    logic [1:0]      state;
    logic [1:0]      div;
    logic [7:0]      wcnt;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   nxt_idx;
    logic [AW:0]     len;
    logic            pred_s;
    logic            ent_taken;
    logic            last_entry;

    assign slowclock  = ~div[1];
    assign nxt_idx    = idx + IDX_ONE;
    assign ent_taken  = mem[idx][PC_W];
    assign last_entry = ({1'b0, idx} == (len - LEN_ONE));

    // Trace storage deliberately survives reset so a reload is not needed after a reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && load_en)
            mem[load_addr] <= {load_taken, load_pc};
    end

    always_ff @(posedge clock) begin
        if (reset)
            div <= '0;
        else
            div <= div + 2'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            wcnt             <= '0;
            idx              <= '0;
            len              <= '0;
            pred_s           <= 1'b0;
            PC               <= '0;
            BranchTaken      <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        branch_count     <= '0;
                        mispredict_count <= '0;
                        if (trace_len != '0) begin
                            state <= RUN;
                            len   <= trace_len;
                            idx   <= '0;
                            wcnt  <= '0;
                            busy  <= 1'b1;
                            PC    <= mem[IDX0][PC_W-1:0];
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wcnt == WSAMP)
                        pred_s <= PredictedBranch;
                    if (wcnt == WLAST) begin
                        BranchTaken <= ent_taken;
                        if (branch_count != '1)
                            branch_count <= branch_count + CNT_ONE;
                        if (pred_s != ent_taken && mispredict_count != '1)
                            mispredict_count <= mispredict_count + CNT_ONE;
                        if (last_entry) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx  <= nxt_idx;
                            wcnt <= '0;
                            PC   <= mem[nxt_idx][PC_W-1:0];
                        end
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_trace_driver.sv
// Directed bench for bp_trace_driver: slowclock phase, trace replay timing,
// statistics, empty trace, busy-time start/load rejection and mid-run reset.
module tb_bp_trace_driver;

    localparam int unsigned WIN = 10;

    logic        clock;
    logic        reset;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [9:0]  load_pc;
    logic        load_taken;
    logic [8:0]  trace_len;
    logic        start;
    logic        PredictedBranch;
    logic [9:0]  PC;
    logic        BranchTaken;
    logic        slowclock;
    logic        busy;
    logic        done;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int checks = 0;
    int failures = 0;

    logic [9:0] shadow_pc [4];
    logic       shadow_tk [4];

    bp_trace_driver dut (
        .clock            (clock),
        .reset            (reset),
        .load_en          (load_en),
        .load_addr        (load_addr),
        .load_pc          (load_pc),
        .load_taken       (load_taken),
        .trace_len        (trace_len),
        .start            (start),
        .PredictedBranch  (PredictedBranch),
        .PC               (PC),
        .BranchTaken      (BranchTaken),
        .slowclock        (slowclock),
        .busy             (busy),
        .done             (done),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [9:0] pc, input logic tk);
        load_en    = 1'b1;
        load_addr  = 8'(a);
        load_pc    = pc;
        load_taken = tk;
        @(negedge clock);
        load_en    = 1'b0;
        shadow_pc[a] = pc;
        shadow_tk[a] = tk;
    endtask

    // Replays n shadow entries with a constant prediction; optionally pokes start/load mid-run.
    task automatic play(input int n, input logic pred, input logic prev_tk, input bit inject);
        int mis = 0;
        PredictedBranch = pred;
        trace_len = 9'(n);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int w = 0; w < n; w++) begin
            if (pred != shadow_tk[w]) mis++;
            for (int c = 0; c < int'(WIN); c++) begin
                check("pc", 32'(PC), 32'(shadow_pc[w]));
                check("busy", 32'(busy), 32'd1);
                check("done_low", 32'(done), 32'd0);
                if (c == 0)
                    check("bt_hold", 32'(BranchTaken), 32'(w == 0 ? prev_tk : shadow_tk[w-1]));
                if (inject && w == 0 && c == 3) begin
                    start      = 1'b1;
                    trace_len  = 9'd1;
                    load_en    = 1'b1;
                    load_addr  = 8'd1;
                    load_pc    = 10'h3FF;
                    load_taken = ~shadow_tk[1];
                end
                @(negedge clock);
                start   = 1'b0;
                load_en = 1'b0;
            end
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fin", 32'(busy), 32'd0);
        check("bt_last", 32'(BranchTaken), 32'(shadow_tk[n-1]));
        check("branch_count", 32'(branch_count), 32'(n));
        check("mispredict_count", 32'(mispredict_count), 32'(mis));
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);
        check("pc_kept", 32'(PC), 32'(shadow_pc[n-1]));
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_pc = '0; load_taken = 1'b0;
        trace_len = '0; start = 1'b0; PredictedBranch = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state and free-running slowclock 1,1,0,0
        for (int k = 0; k < 20; k++) begin
            check("slowclock", 32'(slowclock), 32'((k % 4) < 2));
            check("pc_reset", 32'(PC), 32'd0);
            check("busy_reset", 32'(busy), 32'd0);
            check("cnt_reset", 32'({branch_count, mispredict_count}), 32'd0);
            @(negedge clock);
        end
        check("bt_reset", 32'(BranchTaken), 32'd0);

        // Three-entry trace, prediction always taken: one mispredict
        load(0, 10'h004, 1'b1);
        load(1, 10'h008, 1'b0);
        load(2, 10'h00C, 1'b1);
        play(3, 1'b1, 1'b0, 1'b0);

        // Empty trace: done next cycle, busy never set, PC untouched
        trace_len = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_counts", 32'({branch_count, mispredict_count}), 32'd0);
        check("len0_pc", 32'(PC), 32'h00C);
        @(negedge clock);
        check("len0_done_low", 32'(done), 32'd0);
        check("len0_busy_low", 32'(busy), 32'd0);

        // Identical consecutive PCs
        load(0, 10'h010, 1'b0);
        load(1, 10'h010, 1'b0);
        play(2, 1'b0, 1'b1, 1'b0);

        // start/load_en while busy are ignored; second run reads entry 1 back intact
        load(0, 10'h020, 1'b1);
        load(1, 10'h024, 1'b0);
        play(2, 1'b0, 1'b0, 1'b1);
        play(2, 1'b1, 1'b0, 1'b0);

        // Reset in window 1 cycle 5
        load(0, 10'h004, 1'b1);
        load(1, 10'h008, 1'b0);
        load(2, 10'h00C, 1'b1);
        trace_len = 9'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (15) @(negedge clock);
        check("mid_pc", 32'(PC), 32'h008);
        check("mid_branch_count", 32'(branch_count), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_bt", 32'(BranchTaken), 32'd0);
        check("rst_slowclock", 32'(slowclock), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_counts", 32'({branch_count, mispredict_count}), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            check("rst_no_done", 32'({busy, done}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
